// File: rtl/fft_frame_loader.sv
// Frame loader for FFT_TOP: packs N streamed samples into a parallel frame,
// raises ENABLE and holds the frame frozen until FFT_FINISH comes back.
module fft_frame_loader #(
    parameter int N           = 8,
    parameter int DATA_W      = 16,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  s_valid,
    input  logic [DATA_W-1:0]     s_data,
    output logic                  s_ready,
    input  logic                  flush,
    output logic [N*DATA_W-1:0]   signal_in_time,
    output logic                  ENABLE,
    input  logic                  FFT_FINISH,
    output logic [15:0]           frame_cnt
);

    // state | meaning
    // FILL  | accepting samples into the frame, ENABLE low
    // BUSY  | frame complete and frozen, ENABLE high until FFT_FINISH

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        FILL = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [IDX_W-1:0]     slot;
    logic                 ready_q;
    logic                 accept;
    logic                 last;
    logic [DATA_W-1:0]    frame_q [N];

    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int b = 0; b < IDX_W; b++) begin
            r[b] = v[IDX_W-1-b];
        end
        return r;
    endfunction

    // flush wins over a simultaneous accept
    assign accept = (state == FILL) && ready_q && s_valid && !flush;
    assign last   = accept && (idx == IDX_W'(N - 1));
    assign slot   = BIT_REVERSE ? bitrev(idx) : idx;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (last)       state_nxt = BUSY;
            BUSY: if (FFT_FINISH) state_nxt = FILL;
            default:              state_nxt = FILL;
        endcase
    end

    always_comb begin
        ENABLE  = (state == BUSY);
        s_ready = ready_q;
    end

    // registered decode of the upcoming state keeps s_ready off any input path
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_nxt == FILL);
        end
    end

    always_comb begin
        idx_nxt = idx;
        if (state == FILL) begin
            if (flush) begin
                idx_nxt = '0;
            end else if (accept) begin
                idx_nxt = last ? '0 : idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            idx <= '0;
        end else begin
            idx <= idx_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            for (int j = 0; j < N; j++) begin
                frame_q[j] <= '0;
            end
        end else if (accept) begin
            frame_q[slot] <= s_data;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_bus
        assign signal_in_time[j*DATA_W +: DATA_W] = frame_q[j];
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            frame_cnt <= '0;
        end else if ((state == BUSY) && FFT_FINISH) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: linear and bit-reversed instances share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_fft_frame_loader;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int BW = N * DW;

    logic          CLK = 1'b0;
    logic          nRESET = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          flush = 1'b0;
    logic          FFT_FINISH = 1'b0;

    logic          s_ready0, s_ready1;
    logic          en0, en1;
    logic [BW-1:0] sig0, sig1;
    logic [15:0]   cnt0, cnt1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    fft_frame_loader #(.N(N), .DATA_W(DW), .BIT_REVERSE(1'b0)) u_lin (
        .CLK(CLK), .nRESET(nRESET), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready0), .flush(flush), .signal_in_time(sig0),
        .ENABLE(en0), .FFT_FINISH(FFT_FINISH), .frame_cnt(cnt0)
    );

    fft_frame_loader #(.N(N), .DATA_W(DW), .BIT_REVERSE(1'b1)) u_rev (
        .CLK(CLK), .nRESET(nRESET), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready1), .flush(flush), .signal_in_time(sig1),
        .ENABLE(en1), .FFT_FINISH(FFT_FINISH), .frame_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] pack(input logic [DW-1:0] s [N]);
        logic [BW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = s[j];
        return r;
    endfunction

    // 3-bit reversal written out arithmetically
    function automatic int rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    // Reference model: a frame buffer, a fill pointer and a busy flag
    logic [DW-1:0] m_lin [N] = '{default: '0};
    logic [DW-1:0] m_rev [N] = '{default: '0};
    logic          m_busy  = 1'b0;
    logic          m_ready = 1'b0;
    int            m_idx   = 0;
    logic [15:0]   m_cnt   = '0;

    always @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_idx   <= 0;
            m_cnt   <= '0;
            for (int j = 0; j < N; j++) begin
                m_lin[j] <= '0;
                m_rev[j] <= '0;
            end
        end else if (m_busy) begin
            if (FFT_FINISH) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_cnt   <= m_cnt + 16'd1;
            end
        end else begin
            m_ready <= 1'b1;
            if (flush) begin
                m_idx <= 0;
            end else if (s_valid && m_ready) begin
                m_lin[m_idx]       <= s_data;
                m_rev[rev3(m_idx)] <= s_data;
                if (m_idx == N - 1) begin
                    m_idx   <= 0;
                    m_busy  <= 1'b1;
                    m_ready <= 1'b0;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        chk("ready_lin",  s_ready0, m_ready);
        chk("enable_lin", en0,      m_busy);
        chk("cnt_lin",    cnt0,     m_cnt);
        chk("frame_lin",  sig0,     pack(m_lin));
        chk("ready_rev",  s_ready1, m_ready);
        chk("enable_rev", en1,      m_busy);
        chk("cnt_rev",    cnt1,     m_cnt);
        chk("frame_rev",  sig1,     pack(m_rev));
    end

    task automatic stream(input int base, input int count);
        for (int k = 0; k < count; k++) begin
            s_valid = 1'b1;
            s_data  = DW'(base + k);
            @(negedge CLK);
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_now();
        FFT_FINISH = 1'b1;
        @(negedge CLK);
        FFT_FINISH = 1'b0;
    endtask

    logic [BW-1:0] exp_bus;
    int            en_cycles;
    int            accepts;
    int            cyc;

    initial begin
        #1 nRESET = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_ready",  s_ready0, 1'b0);
        chk("reset_enable", en0, 1'b0);
        chk("reset_frame",  sig0, '0);
        chk("reset_cnt",    cnt0, 16'd0);
        nRESET = 1'b1;
        @(negedge CLK);
        chk("ready_after_release", s_ready0, 1'b1);

        // single frame, ENABLE held 5 cycles
        stream(1, 8);
        exp_bus = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        chk("t1_frame", sig0, exp_bus);
        en_cycles = 0;
        for (int i = 1; i <= 5; i++) begin
            if (en0) en_cycles++;
            chk("t1_ready_busy", s_ready0, 1'b0);
            if (i == 5) FFT_FINISH = 1'b1;
            @(negedge CLK);
        end
        FFT_FINISH = 1'b0;
        chk("t1_enable_cycles", en_cycles, 5);
        chk("t1_enable_low", en0, 1'b0);
        chk("t1_cnt", cnt0, 16'd1);
        chk("t1_ready_back", s_ready0, 1'b1);

        // bit reverse
        stream(0, 8);
        exp_bus = {16'd7, 16'd3, 16'd5, 16'd1, 16'd6, 16'd2, 16'd4, 16'd0};
        chk("t2_bitrev_frame", sig1, exp_bus);
        finish_now();

        // backpressure with random gaps
        accepts = 0;
        cyc = 0;
        while (accepts < 8 && cyc < 200) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            if (s_valid && s_ready0) accepts++;
            cyc++;
            @(negedge CLK);
            if (accepts < 8) chk("t3_no_early_enable", en0, 1'b0);
        end
        s_valid = 1'b0;
        chk("t3_accepts", accepts, 8);
        chk("t3_enable", en0, 1'b1);
        s_valid = 1'b1;
        s_data  = 16'hABCD;
        repeat (3) begin
            @(negedge CLK);
            chk("t3_busy_ready", s_ready0, 1'b0);
        end
        finish_now();
        @(negedge CLK);
        stream(16'h0100, 7);
        chk("t3_enable_b", en0, 1'b1);
        chk("t3_held_sample", sig0[DW-1:0], 16'hABCD);
        finish_now();

        // flush
        stream(100, 3);
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'd999;
        @(negedge CLK);
        flush = 1'b0;
        stream(200, 5);
        chk("t4_no_enable_yet", en0, 1'b0);
        stream(205, 3);
        exp_bus = {16'd207, 16'd206, 16'd205, 16'd204, 16'd203, 16'd202, 16'd201, 16'd200};
        chk("t4_frame", sig0, exp_bus);
        chk("t4_enable", en0, 1'b1);
        flush = 1'b1;
        repeat (2) @(negedge CLK);
        flush = 1'b0;
        chk("t4_busy_flush_enable", en0, 1'b1);
        chk("t4_busy_flush_frame", sig0, exp_bus);
        finish_now();

        // stale finish held through FILL
        FFT_FINISH = 1'b1;
        stream(400, 8);
        chk("t5_enable", en0, 1'b1);
        @(negedge CLK);
        FFT_FINISH = 1'b0;
        chk("t5_one_cycle_busy", en0, 1'b0);
        chk("t5_cnt", cnt0, 16'd6);

        // reset mid-BUSY
        stream(300, 8);
        chk("t6_enable", en0, 1'b1);
        #1 nRESET = 1'b0;
        #1;
        chk("t6_async_enable", en0, 1'b0);
        chk("t6_async_frame", sig0, '0);
        chk("t6_async_cnt", cnt0, 16'd0);
        chk("t6_async_ready", s_ready0, 1'b0);
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        stream(500, 7);
        chk("t6_partial_no_enable", en0, 1'b0);
        stream(507, 1);
        chk("t6_full_enable", en0, 1'b1);
        finish_now();
        chk("t6_cnt", cnt0, 16'd1);

        // random soak against the model
        for (int i = 0; i < 400; i++) begin
            s_valid    = 1'($urandom_range(0, 1));
            s_data     = DW'($urandom);
            flush      = ($urandom_range(0, 9) == 0);
            FFT_FINISH = ($urandom_range(0, 3) == 0);
            @(negedge CLK);
        end
        s_valid    = 1'b0;
        flush      = 1'b0;
        FFT_FINISH = 1'b0;
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Upstream feeder for `FFT_TOP`. It accepts time-domain samples one at a time over a valid/ready stream and packs N of them into the parallel `signal_in_time` frame bus. It then drives `ENABLE` to the FFT and holds the frame stable until `FFT_FINISH` returns. It sits between the sample source and `FFT_TOP` and owns its `ENABLE` input.

## Interface
- `N`, 8: points per frame; power of 2, ≥ 2.
- `DATA_W`, 16: bits per time sample, two's complement.
- `BIT_REVERSE`, 0: 0 = sample k goes to slot k; 1 = sample k goes to slot bitrev(k, log2 N).
- `CLK`  in  1  the single clock; all logic is rising-edge.
- `nRESET`  in  1  asynchronous, active-low reset; deassertion is synchronous to `CLK`.
- `s_valid`  in  1  the source presents a sample.
- `s_data`  in  DATA_W  sample value.
- `s_ready`  out  1  the loader accepts `s_data` this cycle.
- `flush`  in  1  synchronous discard of a partial frame.
- `signal_in_time`  out  N*DATA_W  frame bus; slot j occupies bits [j*DATA_W +: DATA_W].
- `ENABLE`  out  1  starts and holds the FFT run.
- `FFT_FINISH`  in  1  FFT completion from `FFT_TOP`.
- `frame_cnt`  out  16  number of completed frames; wraps at 16 bits.

## Operation
- States: FILL, BUSY.
- **Reset.** Any time `nRESET`=0:
  - state = FILL, write index = 0;
  - `signal_in_time` = 0, `ENABLE` = 0, `frame_cnt` = 0;
  - `s_ready` = 0 while `nRESET` is low, then 1 from the first clock edge after release.
- **FILL.**
  - `s_ready` = 1 and `ENABLE` = 0.
  - Accept = `s_valid` & `s_ready`. On accept, `s_data` is written to slot idx (or bitrev(idx)), and idx is incremented.
  - On the accept that makes idx reach N−1 → N: idx returns to 0 and the state goes to BUSY on the same edge.
- **BUSY.**
  - `s_ready` = 0 and `ENABLE` = 1.
  - `signal_in_time` does not change.
  - When `FFT_FINISH` is sampled 1: state → FILL, `ENABLE` → 0, `frame_cnt` += 1, all on the same edge.
- **flush.**
  - In FILL: idx → 0. Any accept in the same cycle is dropped; flush has priority.
  - Slot contents are not cleared; they are overwritten by the next frame.
  - In BUSY: ignored.
- `FFT_FINISH` is ignored in FILL, including a stale high level. Only a sample taken while in BUSY completes a frame.
- No arithmetic is performed on samples; they are stored bit-exact.
- The `frame_cnt` increment is modulo 2^16.

## Timing
- `s_ready` is a registered state decode. It has no combinational path from `s_valid` or `FFT_FINISH`.
- A sample accepted at edge t is visible on `signal_in_time` after edge t.
- `ENABLE` rises on the edge that accepts the Nth sample, so it is high in the next cycle. The full frame is valid in that same cycle.
- `ENABLE` falls on the edge where `FFT_FINISH`=1 is sampled. `s_ready`=1 from the cycle after that edge.
- Minimum frame period: N accept cycles plus the BUSY cycles. There is no bubble between `FFT_FINISH` and the first accept of the next frame.
- If `FFT_FINISH` is sampled 1 on the first BUSY edge, BUSY lasts exactly 1 cycle.
- If `nRESET` is asserted mid-BUSY, `ENABLE` drops immediately (asynchronously) and the partial run is abandoned.

## Test plan
1. **Single frame.** N=8, BIT_REVERSE=0, reset, stream 1..8 with `s_valid` held high, `FFT_FINISH` pulsed 5 cycles after `ENABLE` rises:
   - slot j = j+1;
   - `ENABLE` high for exactly 5 cycles;
   - `frame_cnt`=1;
   - `s_ready` low throughout BUSY.
2. **Bit reverse.** BIT_REVERSE=1, stream 0..7 → slots hold {0,4,2,6,1,5,3,7}.
3. **Backpressure and gaps.**
   - Toggle `s_valid` randomly, 8 accepts total → `ENABLE` rises only after the 8th accept.
   - Samples presented during BUSY are not taken (`s_ready`=0) and appear as the first samples of the next frame.
4. **Flush.**
   - Accept 3 samples, assert `flush` together with `s_valid` → that sample is dropped and idx = 0.
   - The next 8 samples fill slots 0..7.
   - `flush` during BUSY → no effect.
5. **Stale finish.** Hold `FFT_FINISH`=1 throughout FILL → no state change until the frame completes; BUSY then lasts 1 cycle and `frame_cnt` increments once.
6. **Reset mid-BUSY.** Assert `nRESET`=0 while `ENABLE`=1 → `ENABLE`, `signal_in_time` and `frame_cnt` go to 0 immediately; after release a full new frame is required before `ENABLE` rises.
